// File: rtl/ps2_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_cmd_decoder
//  Purpose  : Turns the PS/2 set-2 byte stream into queued game commands.
//             Tracks E0/F0 prefixes (with a timeout), held-key state and
//             typematic-repeat suppression, and buffers commands in a FIFO
//             drained through a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50   in   system clock
//    reset      in   asynchronous active-high reset
//    rx_data    in   [7:0] received byte
//    rx_valid   in   one-cycle strobe qualifying rx_data
//    cmd_ready  in   consumer takes the head command this cycle
//    cmd_valid  out  FIFO non-empty, cmd_id valid
//    cmd_id     out  key index of the head command
//    key_down   out  [NUM_KEYS-1:0] live held state per key
//    last_code  out  [7:0] last non-prefix byte received
//    overflow   out  sticky: a command was dropped on a full FIFO
// ============================================================================
module ps2_cmd_decoder #(
  parameter int                      NUM_KEYS        = 3,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES       = 24'h23_1B_33,
  parameter logic [NUM_KEYS-1:0]     KEY_EXT         = '0,
  parameter int                      FIFO_DEPTH      = 4,
  parameter int                      REPEAT_SUPPRESS = 1,
  parameter int                      PREFIX_TIMEOUT  = 2_500_000,
  localparam int                     ID_W            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [ID_W-1:0]     cmd_id,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [7:0]          last_code,
  output logic                overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(PREFIX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  state_t          state_q;
  logic [TO_W-1:0] to_cnt_q;

  // --------------------------------------------------------------------------
  // Byte classification and event decode
  // --------------------------------------------------------------------------
  logic is_e0, is_f0, is_ctl;
  logic ev_make, ev_break, ev_ext;

  always_comb begin
    is_e0    = (rx_data == 8'hE0);
    is_f0    = (rx_data == 8'hF0);
    // BAT-OK and error bytes abort any prefix and never form a key event
    is_ctl   = (rx_data == 8'hAA) || (rx_data == 8'hFC);
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (rx_valid && !is_ctl) begin
      case (state_q)
        S_IDLE:   ev_make = !is_e0 && !is_f0;
        S_EXT:    begin
                    ev_make = !is_e0 && !is_f0;
                    ev_ext  = 1'b1;
                  end
        S_BRK:    ev_break = 1'b1;
        S_EXTBRK: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                  end
        default:  ev_make = 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Key table lookup: descending scan so the lowest matching index wins
  // --------------------------------------------------------------------------
  logic                match_hit;
  logic [ID_W-1:0]     match_idx;
  logic [NUM_KEYS-1:0] match_oh;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    match_oh  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if ((rx_data == KEY_CODES[8*i +: 8]) && (ev_ext == KEY_EXT[i])) begin
        match_hit   = 1'b1;
        match_idx   = ID_W'(i);
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefix FSM with inactivity timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
    end else if (rx_valid) begin
      to_cnt_q <= '0;
      if (is_ctl) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (is_e0)      state_q <= S_EXT;
            else if (is_f0) state_q <= S_BRK;
          end
          S_EXT: begin
            if (is_f0)      state_q <= S_EXTBRK;
            else if (!is_e0) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_q  <= S_IDLE;
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_q <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Held-key state and debug byte
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [7:0]          last_code_q;
  logic                suppress;
  logic                push_req;

  always_comb begin
    key_down_d = key_down_q;
    if (ev_make && match_hit)  key_down_d = key_down_q | match_oh;
    if (ev_break && match_hit) key_down_d = key_down_q & ~match_oh;
    suppress = (REPEAT_SUPPRESS != 0) && ((key_down_q & match_oh) != '0);
    push_req = ev_make && match_hit && !suppress;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_down_q  <= '0;
      last_code_q <= 8'h00;
    end else begin
      key_down_q <= key_down_d;
      if (rx_valid && !is_e0 && !is_f0) last_code_q <= rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Command FIFO with registered head
  // --------------------------------------------------------------------------
  logic [ID_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, count_after_pop;
  logic             cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
  logic             overflow_q;
  logic             full, pop, do_push, drop;

  always_comb begin
    full            = (count_q == CNT_FULL);
    pop             = cmd_valid_q && cmd_ready;
    // A pop frees the slot the push needs, so a full FIFO still accepts it
    do_push         = push_req && (!full || pop);
    drop            = push_req && full && !pop;
    count_after_pop = count_q - CNT_W'(pop);
    count_d         = count_after_pop + CNT_W'(do_push);
    wr_ptr_d        = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
    cmd_valid_d     = (count_d != '0);
    if (count_d == '0)
      cmd_id_d = cmd_id_q;
    else if (count_after_pop == '0)
      cmd_id_d = match_idx;       // new entry goes straight to the head
    else
      cmd_id_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_ptr_q] <= match_idx;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign key_down  = key_down_q;
  assign last_code = last_code_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
